// File: rtl/alu_pipelined_n.sv
// Two-stage valid/ready pipelined ALU: S1 registers operands, S2 registers result and flags.
// Optional sticky overflow flag is built only when ALU_STICKY_OVF_EN is defined.
module alu_pipelined_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);
  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_XOR = 3'd2, C_SLT = 3'd3,
                         C_AND = 3'd4, C_NAND = 3'd5, C_NOR = 3'd6, C_OR = 3'd7;

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("alu_pipelined_n: WIDTH must be in 2..64");
    end
  endgenerate

  typedef struct packed {
    logic [2:0]       cmd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_req_t;

  s1_req_t          r_s1;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_ovf, r_zero;

  logic             w_s2_adv, w_sub;
  logic [WIDTH-1:0] w_bx, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf, w_co, w_ov;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  // SLT shares the subtractor; sign of the true difference is sum MSB corrected by overflow
  assign w_sub     = (r_s1.cmd == C_SUB) || (r_s1.cmd == C_SLT);
  assign w_bx      = w_sub ? ~r_s1.b : r_s1.b;
  assign w_sum     = {1'b0, r_s1.a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign w_add_ovf = (r_s1.a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1.a[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    w_ov  = 1'b0;
    case (r_s1.cmd)
      C_ADD, C_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_co  = w_sum[WIDTH];
        w_ov  = w_add_ovf;
      end
      C_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
      C_XOR:  w_res = r_s1.a ^ r_s1.b;
      C_AND:  w_res = r_s1.a & r_s1.b;
      C_NAND: w_res = ~(r_s1.a & r_s1.b);
      C_NOR:  w_res = ~(r_s1.a | r_s1.b);
      C_OR:   w_res = r_s1.a | r_s1.b;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= '{cmd: command, a: a, b: b};
    end
  end

  // Flags and result only move on a real load, so they hold through stalls and bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_carry  <= w_co;
        r_ovf    <= w_ov;
        r_zero   <= (w_res == '0);
      end
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_sticky <= 1'b0;
    else if (w_s2_adv && r_s1_valid && w_ov) r_sticky <= 1'b1;
    else if (sticky_clr)                     r_sticky <= 1'b0;
  end
  assign sticky_ovf = r_sticky;
`else
  logic w_unused_clr;
  assign w_unused_clr = sticky_clr;
  assign sticky_ovf   = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carryout  = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_alu_pipelined_n.sv
// Directed bench for alu_pipelined_n at WIDTH=8: vector table, backpressure, reset, sticky flag.
module tb_alu_pipelined_n;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0]   command = 3'd0;
  logic [W-1:0] a = '0, b = '0, result;
  logic         carryout, overflow, zero, sticky_ovf, sticky_clr = 1'b0;

  int errors = 0, checks = 0;

  alu_pipelined_n #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   cmd;
    logic [W-1:0] a, b, res;
    logic         co, ov, z;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    command = v.cmd; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk($sformatf("v%0d in_ready", idx), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid_early", idx), out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", idx), out_valid, 1);
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d carry", idx), carryout, v.co);
    chk($sformatf("v%0d ovf", idx), overflow, v.ov);
    chk($sformatf("v%0d zero", idx), zero, v.z);
  endtask

  initial begin
    int next, got;
    logic acc, drn;

    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'd5, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 8'hF0, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'd7, 8'hF0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{3'd3, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};

    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst flags", {carryout, overflow, zero}, 0);
    chk("rst sticky", sticky_ovf, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // bubble after drain: valid drops, data holds
    @(posedge clk); #1;
    chk("bubble out_valid", out_valid, 0);
    chk("bubble result hold", result, vecs[13].res);

    // backpressure stream of ADD 1..4
    next = 1; got = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      command = 3'd0; b = '0;
      out_ready = (cyc >= 4);
      in_valid  = (next <= 4);
      a = W'(next);
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (cyc >= 4 && cyc <= 7) chk($sformatf("bp drain c%0d", cyc), drn, 1);
      if (drn) chk($sformatf("bp result %0d", got), result, W'(got));
      @(posedge clk);
      if (acc) next++;
      if (drn) got++;
      #1;
      if (cyc == 1) chk("bp accepts before stall", next, 3);
      if (cyc >= 1 && cyc <= 3) begin
        chk($sformatf("bp stall in_ready c%0d", cyc), in_ready, 0);
        chk($sformatf("bp stall hold c%0d", cyc), result, 8'h01);
        chk($sformatf("bp stall valid c%0d", cyc), out_valid, 1);
      end
    end
    chk("bp all drained", got, 5);
    chk("bp idle valid", out_valid, 0);

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; command = 3'd0; a = 8'h11; b = 8'h22;
    @(negedge clk); a = 8'h33;
    @(negedge clk); in_valid = 1'b0;
    chk("pre-rst out_valid", out_valid, 1);
    chk("pre-rst in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst in_ready", in_ready, 1);
    chk("mid-rst result", result, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst no stale %0d", k), out_valid, 0);
    end
    run_vec(vecs[2], 99);

`ifdef ALU_STICKY_OVF_EN
    chk("sticky clear before ovf", sticky_ovf, 0);
    run_vec(vecs[0], 100);
    chk("sticky set", sticky_ovf, 1);
    run_vec(vecs[1], 101);
    chk("sticky held", sticky_ovf, 1);
    @(negedge clk); sticky_clr = 1'b1;
    @(negedge clk); sticky_clr = 1'b0;
    chk("sticky cleared", sticky_ovf, 0);
`else
    run_vec(vecs[0], 100);
    chk("sticky tied 0", sticky_ovf, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
